ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-port round-robin arbiter and sequencer for the single-port `ram_mem` block (registered read address, read data valid the cycle after the address is presented). It lets two independent requesters (port A, port B) share one RAM instance. For each request it drives the RAM control, address and write data for exactly one cycle, captures read data, and returns a one-cycle acknowledge to the requester. It sits between the two client FSMs and the `ram_mem` instance.

## Interface
- `DATA_WIDTH`, default 8, width of the RAM word; must match the attached `ram_mem`.
- `ADDR_WIDTH`, default 6, width of the RAM address; must match the attached `ram_mem`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_a`, `req_b`  in  1 each  level request; held high until the matching ack.
- `we_a`, `we_b`  in  1 each  1 = write, 0 = read; must be stable while req is high.
- `addr_a`, `addr_b`  in  ADDR_WIDTH each  access address; must be stable while req is high.
- `wdata_a`, `wdata_b`  in  DATA_WIDTH each  write data; must be stable while req is high.
- `ack_a`, `ack_b`  out  1 each  registered one-cycle completion pulse.
- `rdata_a`, `rdata_b`  out  DATA_WIDTH each  registered read result; holds its value until the next read on the same port.
- `busy`  out  1  high when the FSM is not in IDLE.
- `ram_we`  out  1  to `ram_mem.we`.
- `ram_addr`  out  ADDR_WIDTH  to `ram_mem.addr`.
- `ram_data`  out  DATA_WIDTH  to `ram_mem.data`.
- `ram_q`  in  DATA_WIDTH  from `ram_mem.q`.

## Operation
- **FSM states:** IDLE, ACCESS, RESP, ACK. The registers are `sel` (0 = A, 1 = B) and `last` (the last port served).
- **IDLE:**
  - Only one request high: grant it.
  - Both requests high: grant the port with `sel != last`.
  - On a grant, latch `sel` and go to ACCESS.
  - No request: stay in IDLE.
- **ACCESS (one cycle):**
  - `ram_addr` = selected addr, `ram_data` = selected wdata, `ram_we` = selected we.
  - Go to RESP.
- **RESP (one cycle):**
  - `ram_q` now reflects `mem[addr]`.
  - On exit: if the access was a read, load the selected `rdata_x` from `ram_q`.
  - On exit: set the selected `ack_x`, set `last <= sel`, go to ACK.
- **ACK (one cycle):**
  - The selected ack is high.
  - Arbitration considers only the other port.
  - Other port's req high: latch `sel` = other port and go to ACCESS.
  - Otherwise go to IDLE.
  - The acked port's req is ignored in this cycle.
- **RAM drive outside ACCESS:** `ram_we` = 0. `ram_addr` and `ram_data` follow the port currently in `sel`.
- **Requester rule:**
  - Drop req, or present a new operation, in the cycle after the ack.
  - Changing we, addr or wdata while req is high and before ack is illegal.
- **Writes:** `rdata_x` does not change.
- **Reset values (asynchronous):**
  - State = IDLE, `sel` = 0, `last` = 1, so A wins the first tie.
  - `ack_a` = `ack_b` = 0, `rdata_a` = `rdata_b` = 0.
  - `ram_we` = 0 and `busy` = 0 immediately.
- **Reset mid-operation:**
  - The access is aborted and no ack is issued.
  - A write is performed only if a clock edge in ACCESS occurred before `rst` rose.
  - Requesters must reissue the access.

## Timing
- **Single access, FSM idle, req sampled at edge E0:**
  - ACCESS occupies cycle E0–E1.
  - RESP occupies E1–E2.
  - ack and rdata are valid in cycle E2–E3.
  - Latency is 3 cycles from the sampling edge to ack.
- **Back-to-back:** the second port's ACCESS follows the first port's ACK cycle. Sustained alternating throughput is one access per 3 cycles.
- **Same-port repeat:** a new request from the port just served goes ACK → IDLE → ACCESS, i.e. 4 cycles per access.
- **Ack width:** acks are exactly one cycle wide. `ack_a` and `ack_b` are never high together.
- **busy:** low only in IDLE.
- **Write-then-read:** a read of the same address granted after a write's ACK returns the new data.

## Test plan
- **Reset:** assert `rst` mid-cycle with req_a high → all outputs 0 asynchronously. After release with req_a=1, we_a=1, addr_a=5, wdata_a=8'h3C → `ram_we`=1 for one cycle with `ram_addr`=5, and `ack_a` 3 cycles after the first sampling edge.
- **Write-then-read, port A:** A writes 8'hA5 to addr 10, then A reads addr 10 → `rdata_a`=8'hA5 coincident with the second `ack_a`, and `rdata_b` unchanged at 0.
- **Simultaneous requests:** A and B both request from reset → A served first, B's ACCESS in the cycle after `ack_a`. Next simultaneous pair → B served first.
- **Cross-port write-then-read:** A writes 8'h11 to addr 63 while B reads addr 63 in the same cycle → A served first, then `rdata_b`=8'h11.
- **Held request:** B holds req continuously with a new read each ack → ack_b every 4 cycles, and a req_a raised meanwhile is served in the next arbitration with no starvation.
- **Reset during ACCESS of a write** (asserted before the clock edge) → `ram_we` drops immediately, RAM content unchanged, no ack, FSM in IDLE.

Source files
------------

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Two-port round-robin arbiter and sequencer in front of a single-port
// ram_mem (registered read: q is valid the cycle after the address is
// presented). Each granted request drives the RAM for exactly one cycle
// (ACCESS). The read result is captured one cycle later (RESP), and the
// requester then gets a one-cycle acknowledge (ACK).
//
// Ports
//   clk                 single clock, rising edge
//   rst                 asynchronous active-high reset
//   req_a / req_b       level requests, held until the matching ack
//   we_a / we_b         1 = write, 0 = read (stable while req is high)
//   addr_a / addr_b     access address (stable while req is high)
//   wdata_a / wdata_b   write data (stable while req is high)
//   ack_a / ack_b       registered one-cycle completion pulse
//   rdata_a / rdata_b   registered read result, held until next read
//   busy                high whenever the sequencer is not idle
//   ram_we, ram_addr,
//   ram_data            drive to ram_mem.we / .addr / .data
//   ram_q               ram_mem.q
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  ack_a,
    output logic                  ack_b,
    output logic [DATA_WIDTH-1:0] rdata_a,
    output logic [DATA_WIDTH-1:0] rdata_b,
    output logic                  busy,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    // sel: port currently owning the RAM (0 = A, 1 = B).
    // last: port that most recently completed; used to break ties.
    logic sel_reg;
    logic sel_next;
    logic last_reg;
    logic last_next;

    // Port-indexed views of the two requesters so the datapath below is
    // written once and selected by sel_reg.
    logic [1:0]            req;
    logic [1:0]            we;
    logic [ADDR_WIDTH-1:0] addr  [2];
    logic [DATA_WIDTH-1:0] wdata [2];

    logic [1:0]            ack_vec;
    logic [DATA_WIDTH-1:0] rdata_vec [2];

    assign req      = {req_b, req_a};
    assign we       = {we_b, we_a};
    assign addr[0]  = addr_a;
    assign addr[1]  = addr_b;
    assign wdata[0] = wdata_a;
    assign wdata[1] = wdata_b;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
            // last = B so that A wins the first simultaneous request.
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;

        unique case (state_reg)
            IDLE: begin
                if (req[0] && req[1]) begin
                    // Tie: the port that was not served last goes first.
                    sel_next   = ~last_reg;
                    state_next = ACCESS;
                end else if (req[0]) begin
                    sel_next   = 1'b0;
                    state_next = ACCESS;
                end else if (req[1]) begin
                    sel_next   = 1'b1;
                    state_next = ACCESS;
                end
            end

            ACCESS: begin
                state_next = RESP;
            end

            RESP: begin
                last_next  = sel_reg;
                state_next = ACK;
            end

            ACK: begin
                // The port being acked still has req high this cycle, so
                // only the other port may be granted directly from here.
                if (req[~sel_reg]) begin
                    sel_next   = ~sel_reg;
                    state_next = ACCESS;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // RAM drive. Only ACCESS may write; address and data simply follow the
    // selected port so the RAM's registered read sees a stable address.
    // Decoded from the state register so reset kills ram_we at once.
    // -----------------------------------------------------------------------
    assign busy     = (state_reg != IDLE);
    assign ram_we   = (state_reg == ACCESS) && we[sel_reg];
    assign ram_addr = addr[sel_reg];
    assign ram_data = wdata[sel_reg];

    // -----------------------------------------------------------------------
    // Per-port completion: ack pulse and read-data capture on RESP exit.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic                  done;
            logic                  ack_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;

            assign done = (state_reg == RESP) && (sel_reg == gi[0]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= done;
                    // Writes leave the previous read result untouched.
                    if (done && !we[gi]) begin
                        rdata_reg <= ram_q;
                    end
                end
            end

            assign ack_vec[gi]   = ack_reg;
            assign rdata_vec[gi] = rdata_reg;
        end
    endgenerate

    assign ack_a   = ack_vec[0];
    assign ack_b   = ack_vec[1];
    assign rdata_a = rdata_vec[0];
    assign rdata_b = rdata_vec[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Self-checking bench for ram_arbiter with a behavioural single-port RAM
// (registered read) attached. Directed table vectors and hand-written
// sequences cover reset, latency, arbitration order and reset aborts; a
// randomized phase drives both ports and checks every ack against a
// transaction-level memory model.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic          we_a = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic          ack_a, ack_b;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          busy;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q = '0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b),
        .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b),
        .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .busy(busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_q(ram_q)
    );

    // Behavioural ram_mem: write and registered read on the rising edge.
    logic [DW-1:0] mem [64] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    // Reference memory: updated at transaction level when a write is acked.
    logic [DW-1:0] ref_mem [64];

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t tbl [9];

    int            lat, ta, tbb;
    logic [DW-1:0] ra, rb;
    bit            oth;
    int            bcyc [4];
    int            acyc, nb;
    logic [AW-1:0] hb_addr [4];
    bit            pend [2];
    bit            pw [2];
    logic [AW-1:0] pa [2];
    logic [DW-1:0] pd [2];
    int            wt [2];
    logic [DW-1:0] exp_rd [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!p) begin
            req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
        end else begin
            req_b = 1'b1; we_b = w; addr_b = a; wdata_b = d;
        end
    endtask

    task automatic release_port(input bit p);
        if (!p) req_a = 1'b0;
        else    req_b = 1'b0;
    endtask

    // Single request from one port; returns ack latency in negedges.
    task automatic do_op(input bit p, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int l,
                         output logic [DW-1:0] oa, output logic [DW-1:0] ob,
                         output bit other);
        logic my_ack, their_ack;
        l = -1; oa = '0; ob = '0; other = 1'b0;
        drive(p, w, a, d);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            my_ack    = p ? ack_b : ack_a;
            their_ack = p ? ack_a : ack_b;
            if (their_ack) other = 1'b1;
            if (my_ack) begin
                l = c; oa = rdata_a; ob = rdata_b;
                break;
            end
        end
        release_port(p);
        if (l > 0 && w) ref_mem[a] = d;
        $display("op port=%0d we=%0d addr=%0d wdata=%02h lat=%0d rdata_a=%02h rdata_b=%02h",
                 p, w, a, d, l, oa, ob);
    endtask

    // Both ports request in the same cycle; returns each port's ack cycle.
    task automatic pair(input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                        output int t_a, output int t_b,
                        output logic [DW-1:0] oa, output logic [DW-1:0] ob);
        t_a = -1; t_b = -1; oa = '0; ob = '0;
        drive(0, wa, aa, da);
        drive(1, wb, ab, db);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            check("pair_ack_onehot", ack_a & ack_b, 0);
            if (ack_a && t_a < 0) begin
                t_a = c; oa = rdata_a; release_port(0);
                if (wa) ref_mem[aa] = da;
            end
            if (ack_b && t_b < 0) begin
                t_b = c; ob = rdata_b; release_port(1);
                if (wb) ref_mem[ab] = db;
            end
            if (t_a > 0 && t_b > 0) break;
        end
        release_port(0);
        release_port(1);
        $display("pair ack_a@%0d ack_b@%0d rdata_a=%02h rdata_b=%02h", t_a, t_b, oa, ob);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;

        tbl[0] = '{1'b0, 1'b1, 6'd10, 8'hA5, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 6'd10, 8'h00, 8'hA5, 8'h00};
        tbl[2] = '{1'b1, 1'b1, 6'd20, 8'h5A, 8'hA5, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 6'd20, 8'h00, 8'hA5, 8'h5A};
        tbl[4] = '{1'b0, 1'b0, 6'd5,  8'h00, 8'h3C, 8'h5A};
        tbl[5] = '{1'b1, 1'b0, 6'd10, 8'h00, 8'h3C, 8'hA5};
        tbl[6] = '{1'b0, 1'b1, 6'd63, 8'hFF, 8'h3C, 8'hA5};
        tbl[7] = '{1'b0, 1'b0, 6'd63, 8'h00, 8'hFF, 8'hA5};
        tbl[8] = '{1'b1, 1'b0, 6'd7,  8'h00, 8'hFF, 8'h99};

        // ---------------- reset values ----------------
        repeat (2) @(negedge clk);
        check("reset_ack_a", ack_a, 0);
        check("reset_ack_b", ack_b, 0);
        check("reset_busy", busy, 0);
        check("reset_ram_we", ram_we, 0);
        check("reset_rdata_a", rdata_a, 0);
        check("reset_rdata_b", rdata_b, 0);

        // ---------------- asynchronous reset mid-operation ----------------
        rst = 1'b0;
        drive(0, 1'b1, 6'd7, 8'h99);
        repeat (2) @(negedge clk);
        @(posedge clk);            // now in ACK, ack_a is high
        #2 rst = 1'b1;
        #1;
        check("rst_async_ack_a", ack_a, 0);
        check("rst_async_busy", busy, 0);
        check("rst_async_ram_we", ram_we, 0);
        check("rst_async_rdata_a", rdata_a, 0);
        ref_mem[7] = 8'h99;        // its ACCESS edge preceded the reset

        @(negedge clk);
        drive(0, 1'b1, 6'd5, 8'h3C);
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("rst_rel_ram_we", ram_we, (c == 1));
            if (c == 1) check("rst_rel_ram_addr", ram_addr, 5);
            check("rst_rel_ack_a", ack_a, (c == 3));
        end
        release_port(0);
        ref_mem[5] = 8'h3C;
        $display("op port=0 we=1 addr=5 wdata=3c after reset release");
        @(negedge clk);

        // ---------------- table-driven single accesses ----------------
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, ra, rb, oth);
            check("tbl_latency", lat, 3);
            check("tbl_rdata_a", ra, tbl[i].exp_a);
            check("tbl_rdata_b", rb, tbl[i].exp_b);
            check("tbl_other_ack", oth, 0);
            @(negedge clk);
            check("tbl_ack_width", ack_a | ack_b, 0);
            check("tbl_idle_busy", busy, 0);
        end

        // ---------------- simultaneous requests ----------------
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        pair(1'b1, 6'd63, 8'h11, 1'b0, 6'd63, 8'h00, ta, tbb, ra, rb);
        check("pair1_ack_a_cycle", ta, 3);
        check("pair1_ack_b_cycle", tbb, 6);
        check("pair1_rdata_b", rb, 8'h11);
        @(negedge clk);
        do_op(0, 1'b0, 6'd63, 8'h00, lat, ra, rb, oth);
        check("solo_a_latency", lat, 3);
        check("solo_a_rdata", ra, 8'h11);
        @(negedge clk);
        pair(1'b0, 6'd5, 8'h00, 1'b1, 6'd5, 8'h22, ta, tbb, ra, rb);
        check("pair2_ack_b_cycle", tbb, 3);
        check("pair2_ack_a_cycle", ta, 6);
        check("pair2_rdata_a", ra, 8'h22);
        @(negedge clk);

        // ---------------- held request on B, A joins ----------------
        hb_addr[0] = 6'd5; hb_addr[1] = 6'd63; hb_addr[2] = 6'd10; hb_addr[3] = 6'd20;
        for (int i = 0; i < 4; i++) bcyc[i] = -1;
        acyc = -1; nb = 0;
        drive(1, 1'b0, hb_addr[0], 8'h00);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            check("held_ack_onehot", ack_a & ack_b, 0);
            if (ack_b && nb < 4) begin
                bcyc[nb] = c;
                check("held_rdata_b", rdata_b, ref_mem[hb_addr[nb]]);
                $display("held B read addr=%0d rdata_b=%02h at cycle %0d", hb_addr[nb], rdata_b, c);
                nb++;
                if (nb < 4) drive(1, 1'b0, hb_addr[nb], 8'h00);
                else        release_port(1);
            end
            if (ack_a && acyc < 0) begin
                acyc = c;
                ref_mem[40] = 8'h6E;
                release_port(0);
                $display("held A write addr=40 at cycle %0d", c);
            end
            if (c == 8) drive(0, 1'b1, 6'd40, 8'h6E);
            if (nb == 4 && acyc > 0) break;
        end
        release_port(0);
        release_port(1);
        check("held_b_ack0", bcyc[0], 3);
        check("held_b_ack1", bcyc[1], 7);
        check("held_b_ack2", bcyc[2], 14);
        check("held_b_ack3", bcyc[3], 18);
        check("held_a_ack", acyc, 11);
        @(negedge clk);

        // ---------------- reset during ACCESS of a write ----------------
        @(negedge clk);
        drive(0, 1'b1, 6'd30, 8'h77);
        @(negedge clk);
        check("rstacc_ram_we_before", ram_we, 1);
        rst = 1'b1;
        #1;
        check("rstacc_ram_we_after", ram_we, 0);
        check("rstacc_busy", busy, 0);
        check("rstacc_rdata_b", rdata_b, 0);
        repeat (4) begin
            @(negedge clk);
            check("rstacc_no_ack", ack_a, 0);
        end
        check("rstacc_mem_unchanged", mem[30], ref_mem[30]);
        release_port(0);
        rst = 1'b0;
        $display("op port=0 we=1 addr=30 aborted by reset");
        @(negedge clk);

        // ---------------- randomized traffic ----------------
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; wt[p] = 0; exp_rd[p] = '0; pw[p] = 1'b0; pa[p] = '0; pd[p] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            check("rnd_ack_onehot", ack_a & ack_b, 0);
            for (int p = 0; p < 2; p++) begin
                logic          ackp;
                logic [DW-1:0] rdp;
                ackp = p[0] ? ack_b : ack_a;
                rdp  = p[0] ? rdata_b : rdata_a;
                if (pend[p]) wt[p]++;
                if (ackp) begin
                    check("rnd_ack_pending", pend[p], 1);
                    check_range("rnd_latency", wt[p], 3, 6);
                    if (pw[p]) ref_mem[pa[p]] = pd[p];
                    else       exp_rd[p] = ref_mem[pa[p]];
                    check("rnd_rdata", rdp, exp_rd[p]);
                    $display("rnd port=%0d we=%0d addr=%0d wdata=%02h lat=%0d rdata=%02h",
                             p, pw[p], pa[p], pd[p], wt[p], rdp);
                    pend[p] = 1'b0;
                    release_port(p[0]);
                end else if (pend[p] && wt[p] > 6) begin
                    check_range("rnd_timeout", wt[p], 3, 6);
                    pend[p] = 1'b0;
                    release_port(p[0]);
                end else if (!pend[p] && ($urandom % 3) == 0) begin
                    pw[p]   = $urandom_range(0, 1) == 1;
                    pa[p]   = AW'($urandom_range(0, 7));
                    pd[p]   = DW'($urandom);
                    wt[p]   = 0;
                    pend[p] = 1'b1;
                    drive(p[0], pw[p], pa[p], pd[p]);
                end
            end
        end
        release_port(0);
        release_port(1);
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
